// File: rtl/i_line_fill.sv
// Line-fill engine: fetches the 16-byte line holding a miss address from a byte-wide
// req/ack RAM and returns it packed little-endian with a one-cycle done pulse.
module i_line_fill #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = 4,
    parameter int unsigned RAM_WIDTH    = 8,
    parameter int unsigned BENCH_WIDTH  = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cache_read_i,
    input  logic [ADDR_WIDTH-1:0]   cache_addr_i,
    output logic [BENCH_WIDTH-1:0]  cache_data_o,
    output logic                    cache_done_o,
    output logic                    ram_req_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    input  logic [RAM_WIDTH-1:0]    ram_data_i,
    input  logic                    ram_ack_i
);

    localparam int unsigned LINE_BYTES = 1 << SELECT_WIDTH;
    localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - SELECT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [SELECT_WIDTH-1:0] cnt_q,    cnt_d;
    logic [TAG_WIDTH-1:0]    tag_q,    tag_d;
    logic                    req_q,    req_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic                    done_q,   done_d;
    logic [BENCH_WIDTH-1:0]  data_q,   data_d;

    logic                    line_match_c;

    assign line_match_c = (cache_addr_i[ADDR_WIDTH-1:SELECT_WIDTH] == tag_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    // Abort has priority over an ack; the last byte's ack takes priority over count advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        req_d   = req_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                req_d = 1'b0;
                if (cache_read_i) begin
                    tag_d   = cache_addr_i[ADDR_WIDTH-1:SELECT_WIDTH];
                    cnt_d   = '0;
                    addr_d  = {tag_d, SELECT_WIDTH'(0)};
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (!cache_read_i || !line_match_c) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (ram_ack_i) begin
                    for (int k = 0; k < LINE_BYTES; k++) begin
                        if (cnt_q == SELECT_WIDTH'(k)) begin
                            data_d[k*RAM_WIDTH +: RAM_WIDTH] = ram_data_i;
                        end
                    end
                    if (cnt_q == {SELECT_WIDTH{1'b1}}) begin
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d  = SELECT_WIDTH'(cnt_q + 1'b1);
                        addr_d = {tag_q, cnt_d};
                    end
                end
            end

            S_DONE: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign cache_data_o = data_q;
    assign cache_done_o = done_q;
    assign ram_req_o    = req_q;
    assign ram_addr_o   = addr_q;

endmodule

// File: tb/tb_i_line_fill.sv
// Bench for i_line_fill: a transaction-level RAM/line model drives random fills, wait
// states, aborts and resets, and checks addresses, latency, line data and the done pulse.
module tb_i_line_fill;

    logic         clk = 1'b0;
    logic         rst;
    logic         cache_read_i;
    logic [31:0]  cache_addr_i;
    logic [127:0] cache_data_o;
    logic         cache_done_o;
    logic         ram_req_o;
    logic [31:0]  ram_addr_o;
    logic [7:0]   ram_data_i;
    logic         ram_ack_i;

    int checks = 0;
    int errors = 0;
    logic [7:0]   key;
    logic [127:0] last_line;

    i_line_fill dut (
        .clk          (clk),
        .rst          (rst),
        .cache_read_i (cache_read_i),
        .cache_addr_i (cache_addr_i),
        .cache_data_o (cache_data_o),
        .cache_done_o (cache_done_o),
        .ram_req_o    (ram_req_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_i   (ram_data_i),
        .ram_ack_i    (ram_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ key;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        logic [31:0]  base;
        base = {a[31:4], 4'h0};
        for (int k = 0; k < 16; k++) l[8*k +: 8] = mem_byte(base + 32'(k));
        return l;
    endfunction

    // One fill attempt. stop_kind: 0 drop read, 1 switch to new_addr's line, 2 reset;
    // stop_at = number of accepted bytes before the stop (16 = run to completion).
    // ack_mode: 0 always, 1 every third cycle, 2 random.
    task automatic do_fill(input logic [31:0] addr, input int ack_mode, input int stop_at,
                           input int stop_kind, input logic [31:0] new_addr, input bit jitter);
        logic [31:0] base;
        int n, waits, cycles;
        bit fin, stopped;
        base = {addr[31:4], 4'h0};
        n = 0; waits = 0; cycles = 0; fin = 0; stopped = 0;
        cache_read_i = 1'b1;
        cache_addr_i = addr;
        ram_ack_i    = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cycles++;
            if (cycles > 1000) begin
                check_eq("fill_timeout", 128'(n), 128'(stop_at));
                fin = 1;
            end else if (stopped) begin
                check_eq("stop_req_low", 128'(ram_req_o), 128'(0));
                check_eq("stop_no_done", 128'(cache_done_o), 128'(0));
                if (stop_kind == 2) begin
                    check_eq("rst_addr", 128'(ram_addr_o), 128'(0));
                    check_eq("rst_data", cache_data_o, 128'(0));
                    rst = 1'b0;
                end
                ram_ack_i = 1'b0;
                fin = 1;
            end else if (cache_done_o) begin
                check_eq("done_bytes", 128'(n), 128'(16));
                check_eq("done_latency", 128'(cycles), 128'(17 + waits));
                check_eq("line_data", cache_data_o, line_of(addr));
                last_line    = cache_data_o;
                cache_read_i = 1'b0;
                ram_ack_i    = 1'b0;
                @(negedge clk);
                check_eq("done_one_cycle", 128'(cache_done_o), 128'(0));
                check_eq("req_after_done", 128'(ram_req_o), 128'(0));
                check_eq("data_hold", cache_data_o, line_of(addr));
                fin = 1;
            end else begin
                check_eq("req_high", 128'(ram_req_o), 128'(1));
                check_eq("ram_addr", 128'(ram_addr_o), 128'(base + 32'(n)));
                if (jitter) cache_addr_i = {addr[31:4], 4'($urandom)};
                if (n == stop_at) begin
                    ram_ack_i  = 1'b1;
                    ram_data_i = 8'($urandom);
                    case (stop_kind)
                        0: cache_read_i = 1'b0;
                        1: cache_addr_i = new_addr;
                        default: begin
                            rst = 1'b1;
                            cache_read_i = 1'b0;
                        end
                    endcase
                    stopped = 1;
                end else begin
                    case (ack_mode)
                        0: ram_ack_i = 1'b1;
                        1: ram_ack_i = (cycles % 3 == 0);
                        default: ram_ack_i = ($urandom_range(0, 99) >= 40);
                    endcase
                    if (ram_ack_i) begin
                        ram_data_i = mem_byte(base + 32'(n));
                        n++;
                    end else begin
                        ram_data_i = 8'($urandom);
                        waits++;
                    end
                end
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int mode, sa, sk;
        key = 8'h00;
        last_line = '0;

        // Reset held two cycles while a request and acks are present.
        rst = 1'b1; cache_read_i = 1'b1; cache_addr_i = 32'h0000_1234;
        ram_ack_i = 1'b1; ram_data_i = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_req", 128'(ram_req_o), 128'(0));
            check_eq("rst_done", 128'(cache_done_o), 128'(0));
            check_eq("rst_addr0", 128'(ram_addr_o), 128'(0));
            check_eq("rst_data0", cache_data_o, 128'(0));
        end
        rst = 1'b0; cache_read_i = 1'b0; ram_ack_i = 1'b0;
        @(negedge clk);

        // Plain fill with ack tied high; RAM byte = low address byte.
        do_fill(32'h0000_1234, 0, 16, 0, 32'h0, 0);
        check_eq("t2_line_const", last_line, 128'h3F3E3D3C_3B3A3938_37363534_33323130);

        // Ack every third cycle.
        do_fill(32'h0000_1234, 1, 16, 0, 32'h0, 0);

        // Abort after five bytes, then a fresh fill elsewhere.
        do_fill(32'h0000_1234, 0, 5, 0, 32'h0, 0);
        @(negedge clk);
        check_eq("abort_stays_idle", 128'(ram_req_o), 128'(0));
        do_fill(32'h0000_2000, 0, 16, 0, 32'h0, 0);

        // Low-bit address jitter is not an abort; a line change is.
        do_fill(32'h0000_1234, 2, 16, 0, 32'h0, 1);
        do_fill(32'h0000_1234, 0, 7, 1, 32'h0000_5670, 0);
        do_fill(32'h0000_5670, 0, 16, 0, 32'h0, 0);

        // Reset mid-fill, then a normal fill.
        key = 8'h5C;
        do_fill(32'h0000_1234, 0, 9, 2, 32'h0, 0);
        do_fill(32'hABCD_EF07, 2, 16, 0, 32'h0, 0);

        // Acks with no request outstanding are ignored.
        cache_read_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ram_ack_i = 1'b1; ram_data_i = 8'($urandom);
            @(negedge clk);
            check_eq("idle_ack_req", 128'(ram_req_o), 128'(0));
            check_eq("idle_ack_data", cache_data_o, last_line);
        end
        ram_ack_i = 1'b0;

        // Random fills, wait patterns and stops.
        for (int it = 0; it < 12; it++) begin
            key  = 8'($urandom);
            a    = $urandom;
            mode = $urandom_range(0, 2);
            sa   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 16;
            sk   = $urandom_range(0, 2);
            do_fill(a, mode, sa, sk, a ^ 32'h0000_0100, $urandom_range(0, 1) == 1);
            if (sa < 16 && sk == 1) do_fill(a ^ 32'h0000_0100, mode, 16, 0, 32'h0, 0);
            cache_read_i = 1'b0;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
